wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Writeback arbiter. It merges EXU results and queued LSU load
//            results onto a single registered register-file write port, and
//            it keeps a 32-entry pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int LQ_DEPTH = 4  // LSU result queue depth, power of two, >= 2
) (
  input  logic                        clk,
  input  logic                        rst,        // async, active-low
  // issue side
  input  logic                        iss_valid,
  input  logic [4:0]                  iss_rd,
  // EXU result channel
  input  logic                        exu_valid,
  output logic                        exu_ready,
  input  logic [4:0]                  exu_rd,
  input  logic [63:0]                 exu_data,
  // LSU result channel
  input  logic                        lsu_valid,
  output logic                        lsu_ready,
  input  logic [4:0]                  lsu_rd,
  input  logic [63:0]                 lsu_data,
  // register-file write port
  output logic                        wen,
  output logic [4:0]                  waddr,
  output logic [63:0]                 wdata,
  // scoreboard queries
  input  logic [4:0]                  chk_addr1,
  input  logic [4:0]                  chk_addr2,
  output logic                        busy1,
  output logic                        busy2,
  // queue occupancy
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  localparam int                c_PTR_W = $clog2(LQ_DEPTH);
  localparam int                c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(LQ_DEPTH);

  // LSU result queue storage and control
  logic [4:0]          r_lq_rd   [LQ_DEPTH];
  logic [63:0]         r_lq_data [LQ_DEPTH];
  logic [c_PTR_W-1:0]  r_rptr;
  logic [c_PTR_W-1:0]  r_wptr;
  logic [c_CNT_W-1:0]  r_count;

  // write port and scoreboard state
  logic                r_wen;
  logic [4:0]          r_waddr;
  logic [63:0]         r_wdata;
  logic [31:0]         r_busy;

  // combinational selection
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_sel_lq;
  logic                w_sel_exu;
  logic [4:0]          w_sel_rd;
  logic [63:0]         w_sel_data;
  logic                w_wen_next;
  logic [31:0]         w_busy_next;

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  assign exu_ready = ~w_full;
  assign lsu_ready = ~w_full;
  assign w_push    = lsu_valid & ~w_full;

  // Pick at most one result: the LQ head when EXU is idle or the LQ is full,
  // else the EXU. A full LQ implies a non-empty one, so EXU only wins while
  // exu_ready is high and selection equals the EXU handshake.
  always_comb begin
    w_sel_lq   = 1'b0;
    w_sel_exu  = 1'b0;
    w_sel_rd   = exu_rd;
    w_sel_data = exu_data;
    if (!w_empty && (!exu_valid || w_full)) begin
      w_sel_lq   = 1'b1;
      w_sel_rd   = r_lq_rd[r_rptr];
      w_sel_data = r_lq_data[r_rptr];
    end else if (exu_valid) begin
      w_sel_exu  = 1'b1;
    end
    // rd == 0 results are consumed but never written
    w_wen_next = (w_sel_lq || w_sel_exu) && (w_sel_rd != 5'd0);
  end

  // Scoreboard next state: clear on committed write, then set on issue so that
  // a same-edge set wins; x0 is never busy.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wen_next) begin
      w_busy_next[w_sel_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      w_busy_next[iss_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Queue payload storage; contents are meaningless outside [rptr, wptr).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_lq_rd[r_wptr]   <= lsu_rd;
      r_lq_data[r_wptr] <= lsu_data;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at LQ_DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_sel_lq) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_sel_lq})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_wen_next;
      if (w_wen_next) begin
        r_waddr <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign wen      = r_wen;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign lq_count = r_count;
  assign busy1    = r_busy[chk_addr1];
  assign busy2    = r_busy[chk_addr2];

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed self-checking bench for wb_arbiter with a queue-based
//            reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int LQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        exu_valid = 1'b0;
  logic        exu_ready;
  logic [4:0]  exu_rd = '0;
  logic [63:0] exu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [63:0] lsu_data = '0;
  logic        wen;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic [4:0]  chk_addr1 = '0;
  logic [4:0]  chk_addr2 = '0;
  logic        busy1;
  logic        busy2;
  logic [2:0]  lq_count;

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .busy1(busy1), .busy2(busy2),
    .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [4:0] rd; logic [63:0] data; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_busy  = '0;
  logic        m_wen   = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [63:0] m_wdata = '0;
  bit          m_full;
  bit          m_have;
  bit          m_lsu_acc;
  ent_t        m_sel;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_busy  = '0;
      m_wen   = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      m_full    = (m_q.size() == LQ_DEPTH);
      m_lsu_acc = lsu_valid && !m_full;
      m_have    = 1'b0;
      m_sel     = '0;
      if (m_q.size() != 0 && (!exu_valid || m_full)) begin
        m_sel  = m_q.pop_front();
        m_have = 1'b1;
      end else if (exu_valid) begin
        m_sel  = '{rd: exu_rd, data: exu_data};
        m_have = 1'b1;
      end
      if (m_lsu_acc) m_q.push_back('{rd: lsu_rd, data: lsu_data});
      m_wen = m_have && (m_sel.rd != 5'd0);
      if (m_wen) begin
        m_waddr = m_sel.rd;
        m_wdata = m_sel.data;
        m_busy[m_sel.rd] = 1'b0;
      end
      if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    end
  end

  // every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("wen", 64'(wen), 64'(m_wen));
    chk("lq_count", 64'(lq_count), 64'(m_q.size()));
    chk("exu_ready", 64'(exu_ready), 64'(m_q.size() != LQ_DEPTH));
    chk("lsu_ready", 64'(lsu_ready), 64'(m_q.size() != LQ_DEPTH));
    chk("busy1", 64'(busy1), 64'(m_busy[chk_addr1]));
    chk("busy2", 64'(busy2), 64'(m_busy[chk_addr2]));
    if (m_wen) begin
      chk("waddr", 64'(waddr), 64'(m_waddr));
      chk("wdata", wdata, m_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // ---- reset ----
    tick();
    tick();
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_cnt", 64'(lq_count), 64'd0);
    chk("rst_exu_ready", 64'(exu_ready), 64'd1);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    rst = 1'b1;

    // ---- issue rd5, EXU writes rd5 ----
    chk_addr1 = 5'd5;
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0;
    chk("iss_busy1", 64'(busy1), 64'd1);
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 64'h1234;
    tick();
    exu_valid = 1'b0;
    chk("exu_wen", 64'(wen), 64'd1);
    chk("exu_waddr", 64'(waddr), 64'd5);
    chk("exu_wdata", wdata, 64'h1234);
    chk("exu_busy1_clr", 64'(busy1), 64'd0);

    // ---- LSU rd1..4, in-order, 2-cycle latency ----
    for (int i = 1; i <= 4; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(i); lsu_data = 64'h100 + 64'(i);
      tick();
      if (i == 1) begin
        chk("lsu_first_wen", 64'(wen), 64'd0);
        chk("lsu_first_cnt", 64'(lq_count), 64'd1);
      end else begin
        chk("lsu_order_addr", 64'(waddr), 64'(i - 1));
        chk("lsu_steady_cnt", 64'(lq_count), 64'd1);
      end
    end
    lsu_valid = 1'b0;
    tick();
    chk("lsu_last_addr", 64'(waddr), 64'd4);
    chk("lsu_last_data", wdata, 64'h104);
    chk("lsu_empty", 64'(lq_count), 64'd0);
    tick();
    chk("lsu_idle_wen", 64'(wen), 64'd0);

    // ---- fill LQ while EXU busy ----
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 64'h99;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_data = 64'hA0 + 64'(i);
      tick();
    end
    chk("full_cnt", 64'(lq_count), 64'd4);
    chk("full_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("full_exu_ready", 64'(exu_ready), 64'd0);
    chk("full_exu_addr", 64'(waddr), 64'd9);
    lsu_rd = 5'd14; lsu_data = 64'hA4;
    tick();
    chk("drain_cnt", 64'(lq_count), 64'd3);
    chk("drain_addr", 64'(waddr), 64'd10);
    chk("drain_data", wdata, 64'hA0);
    exu_valid = 1'b0;
    lsu_rd = 5'd15; lsu_data = 64'hB5;
    tick();
    chk("pushpop_cnt", 64'(lq_count), 64'd3);
    chk("pushpop_addr", 64'(waddr), 64'd11);
    lsu_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("drain_tail_addr", 64'(waddr), 64'd15);
    chk("drain_tail_data", wdata, 64'hB5);
    chk("drain_tail_cnt", 64'(lq_count), 64'd0);
    tick();

    // ---- EXU rd0 is consumed, no write ----
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 64'hFF;
    chk("rd0_ready", 64'(exu_ready), 64'd1);
    tick();
    exu_valid = 1'b0;
    chk("rd0_wen", 64'(wen), 64'd0);

    // ---- set wins over clear ----
    chk_addr1 = 5'd7;
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 64'h77;
    tick();
    iss_valid = 1'b0; exu_valid = 1'b0;
    chk("setwin_wen", 64'(wen), 64'd1);
    chk("setwin_busy", 64'(busy1), 64'd1);
    exu_valid = 1'b1;
    tick();
    exu_valid = 1'b0;
    chk("clr_busy", 64'(busy1), 64'd0);

    // ---- async reset mid-operation ----
    chk_addr1 = 5'd20; chk_addr2 = 5'd21;
    iss_valid = 1'b1; iss_rd = 5'd20;
    tick();
    iss_rd = 5'd21;
    tick();
    iss_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd12; exu_data = 64'hC0;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(16 + i); lsu_data = 64'hD0 + 64'(i);
      tick();
    end
    chk("pre_rst_cnt", 64'(lq_count), 64'd3);
    chk("pre_rst_wen", 64'(wen), 64'd1);
    chk("pre_rst_busy2", 64'(busy2), 64'd1);
    #3 rst = 1'b0;
    #1;
    chk("arst_wen", 64'(wen), 64'd0);
    chk("arst_cnt", 64'(lq_count), 64'd0);
    chk("arst_busy1", 64'(busy1), 64'd0);
    chk("arst_busy2", 64'(busy2), 64'd0);
    chk("arst_waddr", 64'(waddr), 64'd0);
    chk("arst_wdata", wdata, 64'd0);
    chk("arst_ready", 64'(lsu_ready), 64'd1);
    tick();
    tick();
    chk("in_rst_cnt", 64'(lq_count), 64'd0);
    exu_valid = 1'b0; lsu_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_wen", 64'(wen), 64'd0);
    chk("post_rst_cnt", 64'(lq_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
